// File: rtl/johnson_decode_checker.sv
`default_nettype none
// ============================================================================
// Module   : johnson_decode_checker
// Brief    : Receiver for a WIDTH-bit Johnson counter bus. Registers the
//            incoming code, decodes it to a binary position, classifies every
//            step against the last accepted code and tracks lock, errors and
//            a saturating error count.
// Options  : JOHNSON_DIR_DETECT_EN - accept reverse steps as legal and report
//            the step direction on 'dir' (otherwise 'dir' is tied to 1).
// Revision : 1.0 - initial release
// ============================================================================
module johnson_decode_checker #(
  parameter int WIDTH      = 4,  // Johnson code width, sequence length 2*WIDTH
  parameter int IDX_W      = 3,  // index width, 2**IDX_W >= 2*WIDTH
  parameter int LOCK_COUNT = 3,  // consecutive legal advances needed for lock
  parameter int ERR_W      = 8   // error counter width
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic [WIDTH-1:0] jin,
  output logic [IDX_W-1:0] index,
  output logic             code_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             dir
);

  localparam int c_SEQ_LEN = 2 * WIDTH;
  localparam int c_CNT_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [c_CNT_W-1:0] c_LOCK      = c_CNT_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0]   c_ERR_SAT   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Code for position k: the first WIDTH+1 positions fill with ones from
  // the MSB down, the remaining positions drain ones from the MSB down.
  function automatic logic [WIDTH-1:0] f_code(input int k);
    logic [WIDTH-1:0] code;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) begin
        code[b] = (b >= WIDTH - k);
      end else begin
        code[b] = (b < c_SEQ_LEN - k);
      end
    end
    return code;
  endfunction

  // Stage 1 registers
  logic [WIDTH-1:0] r_sample;
  logic             r_first;   // sample register not yet loaded from jin

  // Stage 2 registers
  state_t           r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ref;
  logic [IDX_W-1:0] r_index;
  logic             r_valid;
  logic             r_err;
  logic [ERR_W-1:0] r_err_count;

  // Decode and next-state signals
  logic [WIDTH-1:0] w_code_tbl [c_SEQ_LEN];
  logic             w_legal;
  logic [IDX_W-1:0] w_sidx;
  logic [WIDTH-1:0] w_next;
  logic             w_hold;
  logic             w_fwd;
  logic             w_rev;
  logic [c_CNT_W-1:0] w_cnt_inc;

  state_t           w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_ref_nxt;
  logic [IDX_W-1:0] w_index_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;

  // Constant table of every legal code, indexed by position
  generate
    for (genvar k = 0; k < c_SEQ_LEN; k++) begin : g_code
      assign w_code_tbl[k] = f_code(k);
    end
  endgenerate

  // Successor of the reference code under the counter's shift rule
  assign w_next    = {~r_ref[0], r_ref[WIDTH-1:1]};
  assign w_hold    = (r_sample == r_ref);
  assign w_fwd     = (r_sample == w_next);
  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef JOHNSON_DIR_DETECT_EN
  logic [WIDTH-1:0] w_prev;
  logic             w_dir_nxt;
  logic             r_dir;

  // Predecessor of the reference code (inverse of the shift rule)
  assign w_prev = {r_ref[WIDTH-2:0], ~r_ref[WIDTH-1]};
  assign w_rev  = (r_sample == w_prev);
`else
  assign w_rev  = 1'b0;
`endif

  // Match the registered sample against the code table
  always_comb begin
    w_legal = 1'b0;
    w_sidx  = '0;
    for (int k = 0; k < c_SEQ_LEN; k++) begin
      if (r_sample == w_code_tbl[k]) begin
        w_legal = 1'b1;
        w_sidx  = IDX_W'(k);
      end
    end
  end

  // Stage 1: capture the bus and note that the pipeline now holds a sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample <= '0;
      r_first  <= 1'b1;
    end else begin
      r_sample <= jin;
      r_first  <= 1'b0;
    end
  end

  // Step classification and lock FSM next-state / output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ref_nxt   = r_ref;
    w_index_nxt = r_index;
    w_valid_nxt = r_valid;
    w_err_nxt   = 1'b0;
`ifdef JOHNSON_DIR_DETECT_EN
    w_dir_nxt   = r_dir;
`endif
    if (!r_first) begin
      if (!w_legal) begin
        // Not a Johnson code: drop lock, keep the last good index/reference
        w_err_nxt   = 1'b1;
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_HUNT;
      end else begin
        w_valid_nxt = 1'b1;
        w_index_nxt = w_sidx;
        w_ref_nxt   = r_sample;
        case (r_state)
          ST_HUNT: begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = '0;
          end
          ST_TRACK: begin
            if (w_hold) begin
              w_state_nxt = ST_TRACK;
            end else if (w_fwd || w_rev) begin
`ifdef JOHNSON_DIR_DETECT_EN
              w_dir_nxt = w_fwd;
`endif
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc == c_LOCK) begin
                w_state_nxt = ST_LOCKED;
              end
            end else begin
              // Jumped to a distant legal code: restart the lock count there
              w_err_nxt = 1'b1;
              w_cnt_nxt = '0;
            end
          end
          ST_LOCKED: begin
            if (w_hold) begin
              w_state_nxt = ST_LOCKED;
            end else if (w_fwd || w_rev) begin
`ifdef JOHNSON_DIR_DETECT_EN
              w_dir_nxt = w_fwd;
`endif
              w_state_nxt = ST_LOCKED;
            end else begin
              w_err_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_TRACK;
            end
          end
          default: begin
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Stage 2: FSM state, reference code and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_cnt       <= '0;
      r_ref       <= '0;
      r_index     <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ref   <= w_ref_nxt;
      r_index <= w_index_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (w_err_nxt && (r_err_count != c_ERR_SAT)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

`ifdef JOHNSON_DIR_DETECT_EN
  // Direction of the last forward/reverse step; resets to "up"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir <= 1'b1;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end

  assign dir = r_dir;
`else
  assign dir = 1'b1;
`endif

  assign index      = r_index;
  assign code_valid = r_valid;
  assign locked     = (r_state == ST_LOCKED);
  assign err        = r_err;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decode_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_decode_checker
// Brief    : Self-checking bench for johnson_decode_checker. A position-based
//            reference model predicts every output each cycle; directed
//            scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_decode_checker;

  localparam int W  = 4;
  localparam int L  = 2 * W;
  localparam int LC = 3;
`ifdef JOHNSON_DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] jin = 4'b0000;
  logic [2:0] index;
  logic       code_valid, locked, err, dir;
  logic [7:0] err_count;

  logic       reset2 = 1'b1;
  logic [3:0] jin2 = 4'b1010;
  logic [2:0] index2;
  logic       code_valid2, locked2, err2, dir2;
  logic [1:0] err_count2;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  johnson_decode_checker #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(3), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .jin(jin), .index(index), .code_valid(code_valid),
    .locked(locked), .err(err), .err_count(err_count), .dir(dir)
  );

  johnson_decode_checker #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(3), .ERR_W(2)) u_dut2 (
    .clk(clk), .reset(reset2), .jin(jin2), .index(index2), .code_valid(code_valid2),
    .locked(locked2), .err(err2), .err_count(err_count2), .dir(dir2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Code at position k: apply the counter rule k times starting from zero
  function automatic logic [3:0] code_of(input int k);
    logic [3:0] c;
    c = 4'b0000;
    for (int i = 0; i < k; i++) c = {~c[0], c[3:1]};
    return c;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int k = 0; k < L; k++) if (code_of(k) == v) return k;
    return -1;
  endfunction

  // Reference model: mode 0=hunting, 1=tracking, 2=locked; positions as ints
  int         m_mode, m_pos, m_cnt;
  logic [3:0] m_samp;
  bit         m_have;
  int         e_index, e_errcnt;
  logic       e_valid, e_err, e_dir;

  always @(posedge clk or negedge reset) begin
    int p, d;
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_cnt = 0; m_have = 1'b0; m_samp = 4'b0000;
      e_index = 0; e_errcnt = 0; e_valid = 1'b0; e_err = 1'b0; e_dir = 1'b1;
    end else begin
      if (m_have) begin
        p = idx_of(m_samp);
        e_err = 1'b0;
        if (p < 0) begin
          e_err = 1'b1; e_valid = 1'b0; m_mode = 0;
        end else begin
          e_valid = 1'b1;
          e_index = p;
          if (m_mode == 0) begin
            m_mode = 1; m_cnt = 0;
          end else begin
            d = (p - m_pos + L) % L;
            if (d == 0) begin
              // hold
            end else if (d == 1 || (DIR_EN && d == L - 1)) begin
              if (DIR_EN) e_dir = (d == 1);
              if (m_mode == 1) begin
                m_cnt++;
                if (m_cnt == LC) m_mode = 2;
              end
            end else begin
              e_err = 1'b1; m_cnt = 0; m_mode = 1;
            end
          end
          m_pos = p;
        end
        if (e_err && e_errcnt < 255) e_errcnt++;
      end
      m_samp = jin;
      m_have = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("index", index, e_index);
      check("code_valid", code_valid, e_valid);
      check("locked", locked, (m_mode == 2));
      check("err", err, e_err);
      check("err_count", err_count, e_errcnt);
      check("dir", dir, e_dir);
    end
  end

  task automatic step(input logic [3:0] v);
    jin = v;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    #1 reset = 1'b0; reset2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_index", index, 0);
    check("rst_valid", code_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_dir", dir, 1);
    cmp_en = 1'b1;
    reset = 1'b1;

    // Acquire: 0000,1000,1100,1110,1111
    step(4'b0000); step(4'b1000);
    check("acq_first_index", index, 0);
    check("acq_first_valid", code_valid, 1);
    step(4'b1100); step(4'b1110);
    check("acq_index2", index, 2);
    check("acq_not_locked", locked, 0);
    step(4'b1111);
    check("acq_index3", index, 3);
    check("acq_locked", locked, 1);

    // Two full cycles including the 7->0 wrap
    for (int k = 5; k <= 20; k++) begin
      step(code_of(k % L));
      if (k == 8) check("wrap_index7", index, 7);
      if (k == 9) check("wrap_index0", index, 0);
    end
    check("wrap_err_count", err_count, 0);
    check("wrap_locked", locked, 1);

    // Illegal code while locked at 1100
    step(4'b0111); step(4'b0011); step(4'b0001); step(4'b0000);
    step(4'b1000); step(4'b1100); step(4'b1010); step(4'b1100);
    check("illegal_err", err, 1);
    check("illegal_valid", code_valid, 0);
    check("illegal_locked", locked, 0);
    check("illegal_err_count", err_count, 1);
    check("illegal_index_hold", index, 2);

    // Relock, then skip 1000 -> 1110, then relock after three advances
    step(4'b1110); step(4'b1111); step(4'b0111); step(4'b0011);
    step(4'b0001); step(4'b0000); step(4'b1000); step(4'b1110);
    check("preskip_locked", locked, 1);
    check("preskip_index", index, 1);
    step(4'b1111);
    check("skip_err", err, 1);
    check("skip_locked", locked, 0);
    check("skip_err_count", err_count, 2);
    check("skip_index", index, 3);
    step(4'b0111); step(4'b0011); step(4'b0001);
    check("relock_locked", locked, 1);
    check("relock_index", index, 6);

    // Asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1;
    check("async_index", index, 0);
    check("async_valid", code_valid, 0);
    check("async_locked", locked, 0);
    check("async_err_count", err_count, 0);
    check("async_dir", dir, 1);
    @(negedge clk);
    reset = 1'b1;

    // Reverse step 1100 -> 1000
    step(4'b0000); step(4'b1000); step(4'b1100); step(4'b1000); step(4'b1000);
`ifdef JOHNSON_DIR_DETECT_EN
    check("rev_err", err, 0);
    check("rev_dir", dir, 0);
`else
    check("rev_err", err, 1);
    check("rev_dir", dir, 1);
    check("rev_err_count", err_count, 1);
`endif

    // Saturating 2-bit error counter fed a constant illegal code
    reset2 = 1'b1;
    @(negedge clk);
    check("sat_initial", err_count2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sat_err_count", err_count2, sat_exp[i]);
    end

    step(4'b1100); step(4'b1100);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
